// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(38,32) SEC scrubber: codeword geometry,
// scrub FSM state encoding and syndrome classification helpers.
package hamming_pkg;

  localparam int unsigned CW_W    = 38;
  localparam int unsigned SYN_W   = 6;
  localparam int unsigned MAX_POS = 38;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CHK,
    WB,
    NEXT
  } scrub_state_t;

  // Syndromes 1..MAX_POS name a single flipped bit; anything above is a multi-bit error.
  function automatic logic syn_correctable(input logic [SYN_W-1:0] s);
    return (s != '0) && (s <= SYN_W'(MAX_POS));
  endfunction

  function automatic logic syn_uncorrectable(input logic [SYN_W-1:0] s);
    return s > SYN_W'(MAX_POS);
  endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_if.sv
// Memory port and error-correction datapath bundle seen by the scrubber.
// master = scrubber side, slave = memory / ECC datapath side.
interface hamming_scrub_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);

  logic                           mem_en;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [hamming_pkg::CW_W-1:0]   mem_wdata;
  logic [hamming_pkg::CW_W-1:0]   mem_rdata;
  logic [hamming_pkg::CW_W-1:0]   chk_word;
  logic [hamming_pkg::CW_W-1:0]   chk_corrected;
  logic [hamming_pkg::SYN_W-1:0]  chk_syndrome;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata, chk_word,
    input  mem_rdata, chk_corrected, chk_syndrome
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata, chk_word,
    output mem_rdata, chk_corrected, chk_syndrome
  );

endinterface

// File: rtl/hamming_scrub_ctrl_sat_counter.sv
// 16-bit (default) saturating event counter with synchronous clear taking
// priority over a same-cycle increment.
module scrub_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Background scrubber for Hamming(38,32) memory; yields the port to the CPU.
// Optional macro SCRUB_IRQ_EN adds err_irq / err_irq_clr behaviour.
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INTERVAL   = 1024,
  parameter int unsigned IRQ_THRESH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scrub_en,
  input  logic                      cpu_req,
  hamming_scrub_ctrl_if.master      bus,
  output logic                      scrub_busy,
  output logic                      pass_done,
  output logic [15:0]               corr_count,
  output logic [15:0]               uncorr_count,
  output logic [ADDR_W-1:0]         last_err_addr,
  output logic                      err_irq,
  input  logic                      err_irq_clr
);

  localparam int unsigned CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  scrub_state_t       r_state;
  scrub_state_t       w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [CW_W-1:0]    r_chk_word;
  logic [CW_W-1:0]    r_wdata;
  logic [ADDR_W-1:0]  r_last_err;

  logic w_cnt_done;
  logic w_syn_corr;
  logic w_syn_uncorr;
  logic w_mem_en;
  logic w_mem_we;
  logic w_pass_done;
  logic w_corr_inc;
  logic w_uncorr_inc;
  logic w_corr_clr;

  assign w_cnt_done   = (r_cnt == CNT_W'(INTERVAL - 1));
  assign w_syn_corr   = syn_correctable(bus.chk_syndrome);
  assign w_syn_uncorr = syn_uncorrectable(bus.chk_syndrome);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (scrub_en && w_cnt_done) w_next = RD;
      RD:      if (!cpu_req) w_next = WAIT;
      WAIT:    w_next = CHK;
      CHK:     w_next = w_syn_corr ? WB : NEXT;
      WB:      if (!cpu_req) w_next = NEXT;
      NEXT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are gated by cpu_req combinationally so the CPU always wins the port.
  always_comb begin
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_pass_done  = 1'b0;
    w_corr_inc   = 1'b0;
    w_uncorr_inc = 1'b0;
    case (r_state)
      RD:   w_mem_en = !cpu_req;
      WB: begin
        w_mem_en = !cpu_req;
        w_mem_we = !cpu_req;
      end
      CHK: begin
        w_corr_inc   = w_syn_corr;
        w_uncorr_inc = w_syn_uncorr;
      end
      NEXT: w_pass_done = (r_addr == '1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_chk_word <= '0;
      r_wdata    <= '0;
      r_last_err <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= (scrub_en && !w_cnt_done) ? r_cnt + 1'b1 : '0;
      end
      if (r_state == WAIT) begin
        r_chk_word <= bus.mem_rdata;
      end
      if ((r_state == CHK) && (w_syn_corr || w_syn_uncorr)) begin
        r_last_err <= r_addr;
      end
      if ((r_state == CHK) && w_syn_corr) begin
        r_wdata <= bus.chk_corrected;
      end
      if (r_state == NEXT) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  scrub_sat_counter #(.W(16)) u_corr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_corr_inc),
    .i_clr   (w_corr_clr),
    .o_count (corr_count)
  );

  scrub_sat_counter #(.W(16)) u_uncorr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_uncorr_inc),
    .i_clr   (1'b0),
    .o_count (uncorr_count)
  );

`ifdef SCRUB_IRQ_EN
  logic r_err_irq;

  assign w_corr_clr = err_irq_clr;

  // Raised on the edge the count reaches the threshold; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_irq <= 1'b0;
    end else if (err_irq_clr) begin
      r_err_irq <= 1'b0;
    end else if (w_corr_inc && (corr_count == 16'(IRQ_THRESH - 1))) begin
      r_err_irq <= 1'b1;
    end
  end

  assign err_irq = r_err_irq;
`else
  logic w_unused_irq;

  assign w_unused_irq = err_irq_clr ^ (IRQ_THRESH != 0);
  assign w_corr_clr   = 1'b0;
  assign err_irq      = 1'b0;
`endif

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.chk_word  = r_chk_word;

  assign scrub_busy    = (r_state != IDLE);
  assign pass_done     = w_pass_done;
  assign last_err_addr = r_last_err;

endmodule

// File: doc/hamming_scrub_ctrl.md
Name: hamming_scrub_ctrl

Overview:
Background scrubber and arbiter for the Hamming-protected (38-bit codeword, 32 data + 6 parity, SEC) data memory. It walks the codeword memory one word at a time and presents each word to the existing combinational error-correction datapath. Words with a single-bit error are written back corrected. The CPU always has priority: the scrubber uses the memory port only in cycles where the CPU does not request it.

Parameters:
ADDR_W, 8, codeword memory address width; depth = 2**ADDR_W
CW_W, 38, codeword width (fixed by encoder; not to be overridden)
INTERVAL, 1024, idle cycles between successive word scrubs (>=1)
IRQ_THRESH, 16, corrected-error count that raises err_irq (only with SCRUB_IRQ_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
scrub_en  in  1  enable background scrubbing
cpu_req  in  1  CPU uses memory port this cycle; scrubber must yield
mem_en  out  1  scrubber memory access strobe
mem_we  out  1  write enable (valid with mem_en)
mem_addr  out  ADDR_W  scrub address
mem_wdata  out  CW_W  corrected codeword for write-back
mem_rdata  in  CW_W  read data, valid 1 cycle after a read strobe
chk_word  out  CW_W  codeword to error-correction datapath
chk_corrected  in  CW_W  corrected codeword (combinational from chk_word)
chk_syndrome  in  6  syndrome (0 = clean, 1..38 = bit position, 39..63 = uncorrectable)
scrub_busy  out  1  high in any state other than IDLE
pass_done  out  1  one-cycle pulse when address wraps to 0
corr_count  out  16  saturating count of corrected words
uncorr_count  out  16  saturating count of uncorrectable syndromes
last_err_addr  out  ADDR_W  address of most recent nonzero syndrome
err_irq  out  1  error interrupt (SCRUB_IRQ_EN only)
err_irq_clr  in  1  clears err_irq and corr_count (SCRUB_IRQ_EN only)

Behaviour:
- Reset: state IDLE, address 0, interval counter 0. All outputs 0, including counters, chk_word, mem_* and err_irq.
- FSM states:
  - IDLE: count up while scrub_en; at INTERVAL-1 go to RD. If scrub_en is low, the counter holds at 0.
  - RD: if !cpu_req, assert mem_en=1, mem_we=0, mem_addr=addr, then go to WAIT; otherwise stay in RD with mem_en=0.
  - WAIT: register mem_rdata into chk_word, then go to CHK.
  - CHK: sample chk_syndrome and chk_corrected.
    - syndrome 0 -> NEXT.
    - syndrome 1..38 -> latch mem_wdata=chk_corrected, set last_err_addr, increment corr_count -> WB.
    - syndrome 39..63 -> increment uncorr_count, set last_err_addr, no write -> NEXT.
  - WB: if !cpu_req, assert mem_en=1, mem_we=1 for one cycle -> NEXT; otherwise wait in WB.
  - NEXT: addr+1 with wrap from 2**ADDR_W-1 to 0; pulse pass_done on wrap -> IDLE.
- Latency: a clean word with no CPU contention takes 4 cycles from leaving IDLE to returning to IDLE. A corrected word takes 5.
- mem_en is never high in a cycle where cpu_req is high. A cpu_req arriving in WAIT/CHK does not affect the read already issued.
- scrub_en deasserted mid-sequence: the current word completes, including write-back. The FSM then stays in IDLE with the address held. Re-enabling resumes at the held address.
- Counters saturate at 16'hFFFF.
- Reset mid-operation aborts any pending write-back; no partial write occurs.

Optional Feature:
SCRUB_IRQ_EN:
- Defined: err_irq is set in the cycle corr_count reaches IRQ_THRESH and stays set until err_irq_clr. err_irq_clr also zeroes corr_count; clear has priority over a same-cycle increment.
- Undefined: err_irq is tied to 0, err_irq_clr is ignored, and corr_count is cleared only by reset.

Decomposition:
- Shared package hamming_pkg holds: CW_W=38, SYN_W=6, MAX_POS=38, and the FSM state typedef (IDLE, RD, WAIT, CHK, WB, NEXT).
- One natural sub-module: scrub_sat_counter, a 16-bit saturating counter with inc and clr inputs, instanced for both counters.

Test Plan:
- Clean memory, INTERVAL=4, ADDR_W=2, scrub_en=1 -> 4 reads, no writes, pass_done pulses once on wrap, both counters 0.
- Word 2 with bit 5 flipped (syndrome 5) -> one write to addr 2 with chk_corrected; corr_count=1, last_err_addr=2.
- Syndrome forced to 45 at addr 1 -> no write, uncorr_count=1, last_err_addr=1.
- cpu_req held high for 10 cycles during RD and during WB -> mem_en stays 0 throughout; access issued in the first cycle cpu_req drops.
- rst pulsed while in WB -> all outputs 0 next edge, no write issued; scrubbing restarts at addr 0.
- SCRUB_IRQ_EN, IRQ_THRESH=2, two corrupted words -> err_irq rises with the second correction; err_irq_clr -> err_irq=0, corr_count=0.
